// File: rtl/gamma_pwm_fader.sv
// Multi-channel PWM fader: a prescaled index walker feeds a power-law gamma ROM, one channel
// per cycle, into shadow compares that are committed as a whole set at the PWM wrap.
module gamma_pwm_fader #(
    parameter int N_CH      = 3,
    parameter int G_PW      = 8,
    parameter int G_OW      = 16,
    parameter int DIV_W     = 17,
    parameter int GAMMA_POW = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [DIV_W-1:0]  step_div,
    input  logic [N_CH-1:0]   ch_invert,
    output logic [N_CH-1:0]   pwm_out,
    output logic              period_start,
    output logic [G_PW-1:0]   idx_out
);

    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int DEPTH = 1 << G_PW;
    localparam logic [G_PW-1:0] IDX_MAX = '1;

    typedef enum logic [1:0] {IDLE, READ, LAST} state_t;

    // Table entry i = i^GAMMA_POW scaled so the full index range spans the output width.
    function automatic logic [G_OW-1:0] gamma_word(input int unsigned i);
        longint unsigned v;
        int sh;
        v = 1;
        for (int k = 0; k < GAMMA_POW; k++) v = v * 64'(i);
        sh = G_OW - GAMMA_POW * G_PW;
        if (sh >= 0) v = v << sh;
        else         v = v >> (-sh);
        return v[G_OW-1:0];
    endfunction

    logic [G_OW-1:0] gamma_rom [DEPTH];

    genvar gi;
    for (gi = 0; gi < DEPTH; gi++) begin : g_rom
        assign gamma_rom[gi] = gamma_word(gi);
    end

    logic [G_OW-1:0]              cnt_reg;
    logic [N_CH-1:0]              pwm_reg, pwm_next;
    logic                         ps_reg;
    logic [G_PW-1:0]              idx_reg, idx_next;
    logic                         dir_reg, dir_next;
    logic [DIV_W-1:0]             div_reg, div_next;
    state_t                       state_reg, state_next;
    logic [CH_W-1:0]              ch_reg, ch_next;
    logic [N_CH-1:0]              inv_reg;
    logic [G_PW-1:0]              rom_addr;
    logic [G_OW-1:0]              rom_data_reg;
    logic                         cap_valid_reg;
    logic [CH_W-1:0]              cap_ch_reg;
    logic [N_CH-1:0][G_OW-1:0]    shadow_reg, shadow_next;
    logic [N_CH-1:0][G_OW-1:0]    ready_reg, ready_next;
    logic [N_CH-1:0][G_OW-1:0]    active_reg, active_next;
    logic                         pending_reg, pending_next;
    logic                         tick, commit;

    for (gi = 0; gi < N_CH; gi++) begin : g_pwm
        assign pwm_next[gi] = (cnt_reg < active_reg[gi]);
    end

    assign rom_addr = inv_reg[ch_reg] ? ~idx_reg : idx_reg;

    always_ff @(posedge CLK) begin
        rom_data_reg <= gamma_rom[rom_addr];
    end

    always_comb begin
        tick     = enable && (state_reg == IDLE) && (div_reg == '0);
        div_next = div_reg;
        if (tick)                            div_next = step_div;
        else if (enable && div_reg != '0)    div_next = div_reg - 1'b1;

        idx_next = idx_reg;
        dir_next = dir_reg;
        if (tick) begin
            case (mode)
                2'd0: begin
                    if (!dir_reg) begin
                        if (idx_reg == IDX_MAX) begin
                            dir_next = 1'b1;
                            idx_next = IDX_MAX - 1'b1;
                        end else begin
                            idx_next = idx_reg + 1'b1;
                        end
                    end else begin
                        if (idx_reg == '0) begin
                            dir_next = 1'b0;
                            idx_next = G_PW'(1);
                        end else begin
                            idx_next = idx_reg - 1'b1;
                        end
                    end
                end
                2'd1:    idx_next = idx_reg + 1'b1;
                default: idx_next = idx_reg;
            endcase
        end

        state_next = state_reg;
        ch_next    = ch_reg;
        case (state_reg)
            IDLE: if (tick) begin
                state_next = READ;
                ch_next    = '0;
            end
            READ: begin
                if (ch_reg == CH_W'(N_CH - 1)) state_next = LAST;
                else                           ch_next    = ch_reg + 1'b1;
            end
            LAST:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // ROM data trails its address by one cycle; the ready bank only ever holds complete sets.
        shadow_next = shadow_reg;
        if (cap_valid_reg) shadow_next[cap_ch_reg] = rom_data_reg;
        ready_next   = (state_reg == LAST) ? shadow_next : ready_reg;
        commit       = (&cnt_reg) && (pending_reg || (state_reg == LAST));
        active_next  = commit ? ready_next : active_reg;
        pending_next = commit ? 1'b0 : (pending_reg || (state_reg == LAST));
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_reg       <= '0;
            pwm_reg       <= '0;
            ps_reg        <= 1'b0;
            idx_reg       <= '0;
            dir_reg       <= 1'b0;
            div_reg       <= '0;
            state_reg     <= IDLE;
            ch_reg        <= '0;
            inv_reg       <= '0;
            cap_valid_reg <= 1'b0;
            cap_ch_reg    <= '0;
            shadow_reg    <= '0;
            ready_reg     <= '0;
            active_reg    <= '0;
            pending_reg   <= 1'b0;
        end else begin
            cnt_reg       <= cnt_reg + 1'b1;
            pwm_reg       <= pwm_next;
            ps_reg        <= (cnt_reg == '0);
            idx_reg       <= idx_next;
            dir_reg       <= dir_next;
            div_reg       <= div_next;
            state_reg     <= state_next;
            ch_reg        <= ch_next;
            if (tick) inv_reg <= ch_invert;
            cap_valid_reg <= (state_reg == READ);
            cap_ch_reg    <= ch_reg;
            shadow_reg    <= shadow_next;
            ready_reg     <= ready_next;
            active_reg    <= active_next;
            pending_reg   <= pending_next;
        end
    end

    assign pwm_out      = pwm_reg;
    assign period_start = ps_reg;
    assign idx_out      = idx_reg;

endmodule

// File: tb/tb_gamma_pwm_fader.sv
// Scoreboard bench for gamma_pwm_fader: a cycle-level reference model pushes expected outputs
// at each clock edge, popped and compared on the following falling edge.
module tb_gamma_pwm_fader;

    localparam int N_CH  = 2;
    localparam int G_PW  = 4;
    localparam int G_OW  = 8;
    localparam int DIV_W = 17;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              enable = 1'b0;
    logic [1:0]        mode = 2'd0;
    logic [DIV_W-1:0]  step_div = '0;
    logic [N_CH-1:0]   ch_invert = 2'b10;
    logic [N_CH-1:0]   pwm_out;
    logic              period_start;
    logic [G_PW-1:0]   idx_out;

    gamma_pwm_fader #(
        .N_CH(N_CH), .G_PW(G_PW), .G_OW(G_OW), .DIV_W(DIV_W), .GAMMA_POW(1)
    ) dut (
        .CLK(CLK), .RST(RST), .enable(enable), .mode(mode), .step_div(step_div),
        .ch_invert(ch_invert), .pwm_out(pwm_out), .period_start(period_start), .idx_out(idx_out)
    );

    always #5 CLK = ~CLK;

    int    n_vec = 0;
    int    n_err = 0;
    string phase = "reset";

    int              m_cnt, m_idx, m_div, m_busy;
    bit              m_dir, m_ps, m_pending;
    logic [N_CH-1:0] m_pwm, m_inv;
    int              m_ready [N_CH];
    int              m_active[N_CH];
    logic [6:0]      exp_q[$];

    int d0, d1, v, dt;

    task automatic check_val(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_idx = 0; m_div = 0; m_busy = 0;
        m_dir = 1'b0; m_ps = 1'b0; m_pending = 1'b0;
        m_pwm = '0; m_inv = '0;
        for (int c = 0; c < N_CH; c++) begin
            m_ready[c]  = 0;
            m_active[c] = 0;
        end
    endtask

    // Spec-level behaviour: a load occupies N_CH+1 cycles and completes on its final edge.
    task automatic model_step();
        bit tick, last, commit;
        tick = enable && (m_busy == 0) && (m_div == 0);
        last = (m_busy == 1);
        for (int c = 0; c < N_CH; c++) m_pwm[c] = (m_cnt < m_active[c]);
        m_ps = (m_cnt == 0);
        if (last)
            for (int c = 0; c < N_CH; c++) m_ready[c] = 16 * (m_inv[c] ? (15 - m_idx) : m_idx);
        commit = (m_cnt == 255) && (m_pending || last);
        if (commit) begin
            for (int c = 0; c < N_CH; c++) m_active[c] = m_ready[c];
            m_pending = 1'b0;
        end else if (last) begin
            m_pending = 1'b1;
        end
        m_cnt = (m_cnt + 1) % 256;
        if (m_busy > 0) m_busy--;
        if (tick) begin
            m_busy = N_CH + 1;
            m_div  = int'(step_div);
            m_inv  = ch_invert;
            case (mode)
                2'd0: begin
                    if (!m_dir) begin
                        if (m_idx == 15) begin m_dir = 1'b1; m_idx = 14; end
                        else m_idx++;
                    end else begin
                        if (m_idx == 0) begin m_dir = 1'b0; m_idx = 1; end
                        else m_idx--;
                    end
                end
                2'd1:    m_idx = (m_idx + 1) % 16;
                default: ;
            endcase
        end else if (enable && m_div != 0) begin
            m_div--;
        end
    endtask

    task automatic cycle();
        logic [6:0] e;
        logic [6:0] g;
        @(posedge CLK);
        if (RST) model_reset();
        else     model_step();
        exp_q.push_back({m_pwm, m_ps, 4'(m_idx)});
        @(negedge CLK);
        e = exp_q.pop_front();
        g = {pwm_out, period_start, idx_out};
        check_val({"out_", phase}, int'(g), int'(e));
    endtask

    task automatic wait_ps();
        int k;
        k = 0;
        while (!period_start && k < 600) begin cycle(); k++; end
        if (!period_start) check_val("ps_timeout", 0, 1);
    endtask

    task automatic measure_period(output int a0, output int a1);
        cycle();
        wait_ps();
        a0 = 0; a1 = 0;
        for (int i = 0; i < 256; i++) begin
            a0 += int'(pwm_out[0]);
            a1 += int'(pwm_out[1]);
            cycle();
        end
        $display("[%s] period duty ch0=%0d ch1=%0d", phase, a0, a1);
    endtask

    task automatic next_idx(output int nv, output int ndt);
        logic [G_PW-1:0] cur;
        cur = idx_out;
        ndt = 0;
        do begin cycle(); ndt++; end while (idx_out == cur && ndt < 50);
        if (idx_out == cur) check_val("idx_step_timeout", 0, 1);
        nv = int'(idx_out);
        $display("[%s] idx %0d -> %0d after %0d cycles", phase, cur, nv, ndt);
    endtask

    task automatic wait_idx(input int target);
        int k;
        k = 0;
        while (int'(idx_out) != target && k < 200) begin cycle(); k++; end
        if (int'(idx_out) != target) check_val("wait_idx_timeout", int'(idx_out), target);
    endtask

    task automatic test_basic();
        enable = 1'b1; mode = 2'd0; ch_invert = 2'b10; RST = 1'b0;
        cycle();
        check_val("first_tick_idx", int'(idx_out), 1);
        mode = 2'd2;
        measure_period(d0, d1);
        check_val("basic_duty0", d0, 16);
        check_val("basic_duty1", d1, 224);
    endtask

    initial begin
        model_reset();
        repeat (3) cycle();
        check_val("reset_out", int'({pwm_out, period_start, idx_out}), 0);

        phase = "basic";
        test_basic();

        phase = "tri";
        mode = 2'd0;
        wait_idx(15);
        next_idx(v, dt); check_val("tri_top", v, 14); check_val("tri_step_cycles", dt, 4);
        next_idx(v, dt); check_val("tri_top2", v, 13);
        wait_idx(0);
        next_idx(v, dt); check_val("tri_bottom", v, 1); check_val("tri_bot_cycles", dt, 4);

        phase = "saw";
        wait_idx(14);
        mode = 2'd1;
        next_idx(v, dt); check_val("saw_a", v, 15);
        next_idx(v, dt); check_val("saw_wrap", v, 0);
        next_idx(v, dt); check_val("saw_b", v, 1);
        phase = "hold";
        mode = 2'd2;
        repeat (40) cycle();
        check_val("hold_idx", int'(idx_out), 1);
        measure_period(d0, d1);
        check_val("hold_duty0", d0, 16);
        check_val("hold_duty1", d1, 224);

        phase = "en_off";
        mode = 2'd0;
        next_idx(v, dt);
        enable = 1'b0;
        check_val("en_off_idx", v, 2);
        repeat (40) cycle();
        check_val("frozen_idx", int'(idx_out), 2);
        measure_period(d0, d1);
        check_val("en_off_duty0", d0, 32);
        check_val("en_off_duty1", d1, 208);

        phase = "edge";
        begin
            int k;
            k = 0;
            while (m_cnt != 252 && k < 300) begin cycle(); k++; end
            if (m_cnt != 252) check_val("edge_align_timeout", m_cnt, 252);
        end
        enable = 1'b1;
        cycle();
        enable = 1'b0;
        measure_period(d0, d1);
        check_val("edge_idx", int'(idx_out), 3);
        check_val("edge_duty0", d0, 48);
        check_val("edge_duty1", d1, 192);

        phase = "mix";
        enable = 1'b1; mode = 2'd0;
        repeat (3) begin
            measure_period(d0, d1);
            check_val("mix_sum", d0 + d1, 240);
        end

        phase = "arst";
        next_idx(v, dt);
        #2 RST = 1'b1;
        #1 check_val("arst_out", int'({pwm_out, period_start, idx_out}), 0);
        model_reset();
        exp_q.delete();
        repeat (3) cycle();
        phase = "after_rst";
        test_basic();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
